lagarto_trap_controller: RTL
============================

Name: lagarto_trap_controller

Overview:
Parametrised machine-mode trap controller for the Lagarto core.
- Takes synchronous exceptions and NUM_INTERRUPTS level-sensitive interrupt lines.
- Owns the M-mode trap CSRs and services CSR read/write/set/clear requests through a valid/ready handshake.
- Drives pipeline flush and PC redirect on trap entry and on mret.
- Sits beside the commit stage and sees retire, PC and exception information.

Parameters:
XLEN, 64, data and CSR width (MXLEN = XLEN).
NUM_INTERRUPTS, 16, number of interrupt lines; line k maps to mip/mie bit k; 1..XLEN-1.
TRAP_VECTOR_RESET, 'h0000_1000, reset value of mtvec.BASE (4-byte aligned).

Ports:
clock_i  in  1  clock.
reset_i  in  1  synchronous, active-high reset.
program_counter_i  in  XLEN  PC of the instruction at commit.
instruction_retired_i  in  1  commit-stage instruction retires this cycle.
exception_valid_i  in  1  commit-stage instruction raised an exception.
exception_cause_i  in  XLEN-1  exception code.
exception_tval_i  in  XLEN  trap value for mtval.
interrupt_lines_i  in  NUM_INTERRUPTS  level interrupt requests, mirrored into mip.
mret_i  in  1  commit-stage mret.
csr_valid_i  in  1  CSR request valid.
csr_command_i  in  2  00 read, 01 write, 10 set, 11 clear.
csr_address_i  in  12  CSR address.
csr_write_data_i  in  XLEN  write/set/clear operand.
csr_ready_o  out  1  CSR request accepted.
csr_read_data_o  out  XLEN  old CSR value.
csr_read_data_valid_o  out  1  read data valid, one-cycle pulse.
csr_illegal_o  out  1  illegal access, one-cycle pulse.
flush_pipeline_o  out  1  one-cycle flush pulse.
redirect_valid_o  out  1  one-cycle redirect pulse.
redirect_pc_o  out  XLEN  redirect target.

Behaviour:
- Reset: state RESET for one cycle, then IDLE. All outputs 0.
  - CSRs cleared except mtvec = {TRAP_VECTOR_RESET[XLEN-1:2], 2'b00}.
  - Reset asserted in any state aborts the operation with no partial CSR update.
- States: RESET, IDLE, WAIT_FOR_RETIRE, TAKE_TRAP, RETURN, CSR_ACCESS.
- Pending interrupt = |(mip & mie) & mstatus.MIE. The highest-index pending line wins.
- Priority in IDLE: exception_valid_i > mret_i > interrupt > csr request.
- csr_ready_o = (state==IDLE) & !exception_valid_i & !mret_i & !pending interrupt.
- IDLE transitions:
  - exception_valid_i → TAKE_TRAP with mcause={0,exception_cause_i}, mepc=program_counter_i, mtval=exception_tval_i.
  - mret_i → RETURN.
  - pending interrupt → WAIT_FOR_RETIRE.
  - csr_valid_i & csr_ready_o → CSR_ACCESS.
- WAIT_FOR_RETIRE:
  - exception_valid_i → take the exception instead; the interrupt stays pending.
  - Interrupt no longer pending → IDLE.
  - instruction_retired_i → TAKE_TRAP with mcause={1,index}, mepc=program_counter_i+4, mtval=0.
- TAKE_TRAP (1 cycle):
  - mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11.
  - flush_pipeline_o=redirect_valid_o=1, redirect_pc_o=trap target.
  - Next state IDLE.
- Trap target = mtvec.BASE; vectored interrupts per the optional feature.
- RETURN (1 cycle): MIE<=MPIE, MPIE<=1, flush and redirect to mepc, then IDLE.
- CSR_ACCESS (1 cycle):
  - csr_read_data_o = value before the access, csr_read_data_valid_o=1.
  - Write/set/clear committed at end of cycle; next state IDLE.
- Set/clear with operand 0 performs no write.
- Implemented CSRs: mstatus 0x300 (only MIE b3, MPIE b7, MPP b12:11 writable; MPP reads 11), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only).
- mie and mip bits ≥ NUM_INTERRUPTS read 0.
- Unknown address, or write/set/clear to mip: csr_illegal_o=1 in CSR_ACCESS, read data 0, no state change.
- mtvec.BASE low bits [1:0] always read 0.

Optional Feature:
LAGARTO_TRAP_VECTORED_EN.
- Defined: mtvec.MODE (bits 1:0) is writable with values 00 or 01; other written values keep the old MODE. With MODE=01, the interrupt target is BASE + 4*index; exceptions always go to BASE.
- Undefined: MODE is hardwired to 00 and all traps go to BASE.

Test Plan:
- Reset, read mtvec (cmd 00, addr 0x305) → csr_read_data_o='h1000, valid 1 cycle after accept.
- exception_valid_i=1, cause 2, PC='h2000, tval='hDEAD → next cycle flush/redirect to 'h1000; mepc='h2000, mcause=2, mtval='hDEAD, mstatus.MIE=0.
- mie[7]=1, MIE=1, line 7 raised, retire held low 3 cycles then PC='h3000 retires → TAKE_TRAP one cycle later, mepc='h3004, mcause={1,7}; with LAGARTO_TRAP_VECTORED_EN and MODE=01 redirect='h101C.
- Exception and mret same cycle → trap taken, no RETURN; then mret → redirect to mepc, MIE restored to 1.
- Write to 0x344 or read 0x7FF → csr_illegal_o pulse, mip/CSRs unchanged; set mie with 0 → no change.
- Reset asserted in WAIT_FOR_RETIRE → no flush, state IDLE after RESET, mepc=0.

Source files
------------

// File: rtl/lagarto_trap_controller.sv
// lagarto_trap_controller: machine-mode trap controller for the Lagarto core.
// Owns the M-mode trap CSRs, serves CSR requests, and drives flush/redirect
// on trap entry and mret.
// Optional feature macro: LAGARTO_TRAP_VECTORED_EN (vectored interrupt targets
// through a writable mtvec.MODE field; when undefined MODE reads 00).

module lagarto_trap_controller #(
  parameter int unsigned     XLEN              = 64,
  parameter int unsigned     NUM_INTERRUPTS    = 16,
  parameter logic [XLEN-1:0] TRAP_VECTOR_RESET = 'h0000_1000
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [XLEN-1:0]           program_counter_i,
  input  logic                      instruction_retired_i,
  input  logic                      exception_valid_i,
  input  logic [XLEN-2:0]           exception_cause_i,
  input  logic [XLEN-1:0]           exception_tval_i,
  input  logic [NUM_INTERRUPTS-1:0] interrupt_lines_i,
  input  logic                      mret_i,
  input  logic                      csr_valid_i,
  input  logic [1:0]                csr_command_i,
  input  logic [11:0]               csr_address_i,
  input  logic [XLEN-1:0]           csr_write_data_i,
  output logic                      csr_ready_o,
  output logic [XLEN-1:0]           csr_read_data_o,
  output logic                      csr_read_data_valid_o,
  output logic                      csr_illegal_o,
  output logic                      flush_pipeline_o,
  output logic                      redirect_valid_o,
  output logic [XLEN-1:0]           redirect_pc_o
);

  localparam int unsigned IDX_W = (NUM_INTERRUPTS > 1) ? $clog2(NUM_INTERRUPTS) : 1;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_WAIT_FOR_RETIRE,
    S_TAKE_TRAP,
    S_RETURN,
    S_CSR_ACCESS
  } state_t;

  state_t state;

  // Architectural CSR storage (only the implemented bits are kept)
  logic                      mstatus_mie;
  logic                      mstatus_mpie;
  logic [NUM_INTERRUPTS-1:0] mie_q;
  logic [NUM_INTERRUPTS-1:0] mip_q;
  logic [XLEN-3:0]           mtvec_base;
  logic [1:0]                mtvec_mode;
  logic [XLEN-1:0]           mscratch;
  logic [XLEN-1:0]           mepc;
  logic [XLEN-1:0]           mcause;
  logic [XLEN-1:0]           mtval;

  // Latched CSR request, consumed in CSR_ACCESS
  logic [1:0]                req_cmd;
  logic [11:0]               req_addr;
  logic [XLEN-1:0]           req_data;

  logic [NUM_INTERRUPTS-1:0] pending_vec;
  logic                      irq_pending;
  logic [IDX_W-1:0]          irq_index;
  logic                      take_exception;
  logic [XLEN-1:0]           mstatus_value;
  logic [XLEN-1:0]           trap_base;
  logic [XLEN-1:0]           interrupt_target;
  logic                      csr_known;
  logic [XLEN-1:0]           csr_value;
  logic                      csr_illegal_next;
  logic [XLEN-1:0]           csr_new_value;
  logic                      csr_do_write;

`ifdef LAGARTO_TRAP_VECTORED_EN
  logic [1:0] mtvec_mode_q;
  assign mtvec_mode = mtvec_mode_q;
`else
  assign mtvec_mode = 2'b00;
`endif

  assign trap_base = {mtvec_base, 2'b00};

  // Pick the highest-index enabled pending interrupt line
  always_comb begin
    pending_vec = mip_q & mie_q;
    irq_pending = (|pending_vec) & mstatus_mie;
    irq_index   = '0;
    for (int k = 0; k < NUM_INTERRUPTS; k++) begin
      if (pending_vec[k]) irq_index = IDX_W'(k);
    end
  end

  assign take_exception = exception_valid_i &
                          ((state == S_IDLE) || (state == S_WAIT_FOR_RETIRE));

  assign csr_ready_o = (state == S_IDLE) & ~exception_valid_i & ~mret_i & ~irq_pending;

  // Interrupt target: BASE, or BASE + 4*index when vectored mode is selected
  always_comb begin
    interrupt_target = trap_base;
    if (mtvec_mode == 2'b01) begin
      interrupt_target = trap_base + (XLEN'(irq_index) << 2);
    end
  end

  // Compose mstatus; MPP is hardwired to machine mode
  always_comb begin
    mstatus_value        = '0;
    mstatus_value[3]     = mstatus_mie;
    mstatus_value[7]     = mstatus_mpie;
    mstatus_value[12:11] = 2'b11;
  end

  // Read mux for the incoming request address, with legality decode
  always_comb begin
    csr_known = 1'b1;
    csr_value = '0;
    case (csr_address_i)
      ADDR_MSTATUS:  csr_value = mstatus_value;
      ADDR_MIE:      csr_value = XLEN'(mie_q);
      ADDR_MTVEC:    csr_value = {mtvec_base, mtvec_mode};
      ADDR_MSCRATCH: csr_value = mscratch;
      ADDR_MEPC:     csr_value = mepc;
      ADDR_MCAUSE:   csr_value = mcause;
      ADDR_MTVAL:    csr_value = mtval;
      ADDR_MIP:      csr_value = XLEN'(mip_q);
      default:       csr_known = 1'b0;
    endcase
    csr_illegal_next = ~csr_known |
                       ((csr_address_i == ADDR_MIP) && (csr_command_i != CMD_READ));
  end

  // New CSR value from the old value held on the read-data register
  always_comb begin
    csr_new_value = csr_read_data_o;
    case (req_cmd)
      2'b01:   csr_new_value = req_data;
      2'b10:   csr_new_value = csr_read_data_o | req_data;
      2'b11:   csr_new_value = csr_read_data_o & ~req_data;
      default: csr_new_value = csr_read_data_o;
    endcase
    csr_do_write = (req_cmd == CMD_WRITE) | (req_cmd[1] & (req_data != '0));
  end

  // Trap FSM with registered outputs and all CSR state updates
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state                 <= S_RESET;
      mstatus_mie           <= 1'b0;
      mstatus_mpie          <= 1'b0;
      mie_q                 <= '0;
      mip_q                 <= '0;
      mtvec_base            <= TRAP_VECTOR_RESET[XLEN-1:2];
`ifdef LAGARTO_TRAP_VECTORED_EN
      mtvec_mode_q          <= 2'b00;
`endif
      mscratch              <= '0;
      mepc                  <= '0;
      mcause                <= '0;
      mtval                 <= '0;
      req_cmd               <= CMD_READ;
      req_addr              <= '0;
      req_data              <= '0;
      csr_read_data_o       <= '0;
      csr_read_data_valid_o <= 1'b0;
      csr_illegal_o         <= 1'b0;
      flush_pipeline_o      <= 1'b0;
      redirect_valid_o      <= 1'b0;
      redirect_pc_o         <= '0;
    end else begin
      mip_q                 <= interrupt_lines_i;
      csr_read_data_o       <= '0;
      csr_read_data_valid_o <= 1'b0;
      csr_illegal_o         <= 1'b0;
      flush_pipeline_o      <= 1'b0;
      redirect_valid_o      <= 1'b0;
      redirect_pc_o         <= '0;

      if (take_exception) begin
        mcause           <= {1'b0, exception_cause_i};
        mepc             <= {program_counter_i[XLEN-1:2], 2'b00};
        mtval            <= exception_tval_i;
        flush_pipeline_o <= 1'b1;
        redirect_valid_o <= 1'b1;
        redirect_pc_o    <= trap_base;
        state            <= S_TAKE_TRAP;
      end else begin
        case (state)
          S_RESET: state <= S_IDLE;

          S_IDLE: begin
            if (mret_i) begin
              flush_pipeline_o <= 1'b1;
              redirect_valid_o <= 1'b1;
              redirect_pc_o    <= mepc;
              state            <= S_RETURN;
            end else if (irq_pending) begin
              state <= S_WAIT_FOR_RETIRE;
            end else if (csr_valid_i) begin
              req_cmd               <= csr_command_i;
              req_addr              <= csr_address_i;
              req_data              <= csr_write_data_i;
              csr_read_data_o       <= csr_illegal_next ? '0 : csr_value;
              csr_read_data_valid_o <= 1'b1;
              csr_illegal_o         <= csr_illegal_next;
              state                 <= S_CSR_ACCESS;
            end
          end

          S_WAIT_FOR_RETIRE: begin
            if (!irq_pending) begin
              state <= S_IDLE;
            end else if (instruction_retired_i) begin
              mcause           <= {1'b1, (XLEN-1)'(irq_index)};
              mepc             <= {program_counter_i[XLEN-1:2] + 1'b1, 2'b00};
              mtval            <= '0;
              flush_pipeline_o <= 1'b1;
              redirect_valid_o <= 1'b1;
              redirect_pc_o    <= interrupt_target;
              state            <= S_TAKE_TRAP;
            end
          end

          S_TAKE_TRAP: begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            state        <= S_IDLE;
          end

          S_RETURN: begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            state        <= S_IDLE;
          end

          S_CSR_ACCESS: begin
            if (!csr_illegal_o && csr_do_write) begin
              case (req_addr)
                ADDR_MSTATUS: begin
                  mstatus_mie  <= csr_new_value[3];
                  mstatus_mpie <= csr_new_value[7];
                end
                ADDR_MIE:      mie_q <= csr_new_value[NUM_INTERRUPTS-1:0];
                ADDR_MTVEC: begin
                  mtvec_base <= csr_new_value[XLEN-1:2];
`ifdef LAGARTO_TRAP_VECTORED_EN
                  if (!csr_new_value[1]) mtvec_mode_q <= csr_new_value[1:0];
`endif
                end
                ADDR_MSCRATCH: mscratch <= csr_new_value;
                ADDR_MEPC:     mepc     <= {csr_new_value[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause   <= csr_new_value;
                ADDR_MTVAL:    mtval    <= csr_new_value;
                default:       ;
              endcase
            end
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
